// File: rtl/cheshire_pkg.sv
// Cheshire platform constants used by the end-of-computation monitor.
// ScratchRegsBase is the base of the SoC scratch register file; the
// exit-status register sits one 32-bit word above it.
package cheshire_pkg;

  localparam logic [63:0] ScratchRegsBase = 64'h0000_0000_0300_0000;

endpackage

// File: rtl/cheshire_eoc_monitor_counter.sv
// Up counter with synchronous clear and count enable (common_cells-style
// counter interface, reduced to the controls the monitor drives).
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, forces q_o to 0
//   clear_i : synchronous clear, wins over en_i
//   en_i    : increment by one this cycle
//   q_o     : current count
module cheshire_eoc_monitor_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        q_o <= '0;
    else if (clear_i) q_o <= '0;
    else if (en_i)    q_o <= q_o + Width'(1);
  end

endmodule

// File: rtl/cheshire_eoc_monitor.sv
// End-of-computation monitor. Snoops register-bus writes to the exit-status
// scratch register; once armed, a full-strobe write with bit 0 set reports
// exit code = data[31:1]. An optional timeout reports all-ones with
// timeout_o set. The result is held under a valid/ready handshake.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   arm_i            : start / restart monitoring (ignored while reporting)
//   snoop_*          : observed bus request (valid, ready, write, addr,
//                      wdata, wstrb)
//   eoc_valid_o      : result available, eoc_ready_i consumes it
//   exit_code_o      : reported exit code
//   timeout_o        : result was produced by the timeout
//   busy_o           : monitor is armed
module cheshire_eoc_monitor
  import cheshire_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter logic [63:0] EocAddr       = ScratchRegsBase + 64'd4,
  parameter logic [31:0] TimeoutCycles = 32'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   arm_i,
  input  logic                   snoop_valid_i,
  input  logic                   snoop_ready_i,
  input  logic                   snoop_write_i,
  input  logic [AddrWidth-1:0]   snoop_addr_i,
  input  logic [DataWidth-1:0]   snoop_wdata_i,
  input  logic [DataWidth/8-1:0] snoop_wstrb_i,
  output logic                   eoc_valid_o,
  input  logic                   eoc_ready_i,
  output logic [30:0]            exit_code_o,
  output logic                   timeout_o,
  output logic                   busy_o
);

  localparam int unsigned NUM_LANES = DataWidth / 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  logic [1:0] state_q, state_d;

  logic [NUM_LANES-1:0][31:0] lane_data;
  logic [NUM_LANES-1:0][3:0]  lane_strb;
  logic [31:0]                lw;
  logic [3:0]                 ls;
  logic                       hit, eoc, tmo;
  logic                       cnt_clr, cnt_en;
  logic [31:0]                cnt_q;
  logic                       unused_addr;

  // The word address selects the 32-bit half of the 64-bit beat.
  assign lane_data = snoop_wdata_i;
  assign lane_strb = snoop_wstrb_i;
  assign lw        = lane_data[snoop_addr_i[2]];
  assign ls        = lane_strb[snoop_addr_i[2]];

  assign unused_addr = ^snoop_addr_i[1:0];

  assign hit = snoop_valid_i & snoop_ready_i & snoop_write_i &
               (snoop_addr_i[AddrWidth-1:2] == EocAddr[AddrWidth-1:2]);

  // Partial-strobe writes and even values never terminate the run.
  assign eoc = (state_q == ARMED) & hit & (&ls) & lw[0];

  // Counter reads 0 in the first armed cycle, so TimeoutCycles-1 is the
  // last armed cycle; an EOC in that same cycle takes precedence.
  assign tmo = (state_q == ARMED) & (TimeoutCycles != 32'd0) &
               (cnt_q == TimeoutCycles - 32'd1) & ~eoc;

  // Held at zero outside ARMED so every entry starts from 0; re-arm restarts.
  assign cnt_clr = (state_q != ARMED) | arm_i;
  assign cnt_en  = (state_q == ARMED) & ~(&cnt_q);

  cheshire_eoc_monitor_counter #(
    .Width ( 32 )
  ) i_cnt (
    .clk_i   ( clk_i   ),
    .rst_i   ( rst_i   ),
    .clear_i ( cnt_clr ),
    .en_i    ( cnt_en  ),
    .q_o     ( cnt_q   )
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm_i)       state_d = ARMED;
      ARMED:   if (eoc | tmo)   state_d = REPORT;
      REPORT:  if (eoc_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they track state_q
  // exactly without decode glitches.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      eoc_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      exit_code_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      eoc_valid_o <= (state_d == REPORT);
      busy_o      <= (state_d == ARMED);
      if (eoc) begin
        exit_code_o <= lw[31:1];
        timeout_o   <= 1'b0;
      end else if (tmo) begin
        exit_code_o <= '1;
        timeout_o   <= 1'b1;
      end
    end
  end

endmodule
